// File: rtl/sw_pkg.sv
// Shared Smith-Waterman package, common to the PE chain and the score collector.
// Holds the score width and bias, gap penalties, nucleotide codes, a score-max
// helper and the one-hot state encoding of the score collector.
package sw_pkg;

    localparam int SCORE_WIDTH = 11;
    // Offset-binary bias: this raw value encodes a score of zero.
    localparam logic [SCORE_WIDTH-1:0] NEUTRAL = 11'b100_0000_0000;

    localparam int GOPEN = 3;
    localparam int GEXT  = 1;

    typedef enum logic [1:0] {
        NT_A = 2'd0,
        NT_C = 2'd1,
        NT_G = 2'd2,
        NT_T = 2'd3
    } nucleotide_t;

    // Offset-binary scores order correctly under a plain unsigned compare.
    function automatic logic [SCORE_WIDTH-1:0] score_max(
        input logic [SCORE_WIDTH-1:0] a,
        input logic [SCORE_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_COLLECT = 3'b010,
        ST_HOLD    = 3'b100
    } collector_state_t;

endpackage

// File: rtl/sw_score_collector_if.sv
// Bus between the last PE / host and the score collector.
// master: upstream side (drives en/scores/mode and the consumer's ready).
// slave : the collector (drives busy, the result bundle and the state debug tap).
//
// Handshake: a result is transferred on every rising clk edge where o_valid and
// i_ready are both 1. While o_valid=1 and i_ready=0 the result outputs are held
// stable. i_ready is ignored while o_valid=0.
interface sw_score_collector_if #(
    parameter int SCORE_WIDTH = sw_pkg::SCORE_WIDTH,
    parameter int POS_WIDTH   = 16
);
    logic                   i_en;
    logic [SCORE_WIDTH-1:0] i_high;
    logic [SCORE_WIDTH-1:0] i_right_m;
    logic [SCORE_WIDTH-1:0] i_right_i;
    logic                   i_local;
    logic                   i_ready;
    logic                   o_busy;
    logic                   o_valid;
    logic [SCORE_WIDTH-1:0] o_score;
    logic [POS_WIDTH-1:0]   o_end_pos;
    logic [POS_WIDTH-1:0]   o_length;
    logic                   o_len_sat;
    logic                   o_overrun;
    sw_pkg::collector_state_t dbg_state;

    modport master (
        output i_en, i_high, i_right_m, i_right_i, i_local, i_ready,
        input  o_busy, o_valid, o_score, o_end_pos, o_length, o_len_sat,
               o_overrun, dbg_state
    );

    modport slave (
        input  i_en, i_high, i_right_m, i_right_i, i_local, i_ready,
        output o_busy, o_valid, o_score, o_end_pos, o_length, o_len_sat,
               o_overrun, dbg_state
    );
endinterface

// File: rtl/sw_max2.sv
// Register-free two-input unsigned maximum. On a tie it returns b, so a caller
// comparing a new value (a) against a held one (b) sees a change only when a is
// strictly greater.
// Ports: a, b (W bits) in; y = max(a, b) out.
module sw_max2 #(
    parameter int W = 11
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = (a > b) ? a : b;
endmodule

// File: rtl/sw_score_collector.sv
// Score collector behind the last PE of the Smith-Waterman chain. Tracks the
// running high score, the last-column cell score and the best last-column
// position while a target streams through, then forms one alignment result
// when the PE enable falls and holds it on a valid/ready handshake.
// Ports: clk, rst (sync, active-high); bus (slave modport): i_en, i_high,
// i_right_m, i_right_i, i_local, i_ready in; o_busy, o_valid, o_score,
// o_end_pos, o_length, o_len_sat, o_overrun, dbg_state out.
module sw_score_collector #(
    parameter int                     SCORE_WIDTH = sw_pkg::SCORE_WIDTH,
    parameter logic [SCORE_WIDTH-1:0] NEUTRAL     = sw_pkg::NEUTRAL,
    parameter int                     POS_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    sw_score_collector_if.slave bus
);
    import sw_pkg::*;

    collector_state_t       state;
    logic [SCORE_WIDTH-1:0] last_high;
    logic [SCORE_WIDTH-1:0] last_col;
    logic [SCORE_WIDTH-1:0] best;
    logic [POS_WIDTH-1:0]   cnt;
    logic [POS_WIDTH-1:0]   best_pos;
    logic                   mode_local;
    logic                   sat;

    logic [SCORE_WIDTH-1:0] score_q;
    logic [POS_WIDTH-1:0]   end_pos_q;
    logic [POS_WIDTH-1:0]   length_q;
    logic                   len_sat_q;
    logic                   overrun_q;

    logic [SCORE_WIDTH-1:0] col_now;
    logic [SCORE_WIDTH-1:0] best_next;
    logic [POS_WIDTH-1:0]   cnt_inc;
    logic                   cnt_full;
    logic                   start;

    sw_max2 #(.W(SCORE_WIDTH)) u_col_max (
        .a (bus.i_right_m),
        .b (bus.i_right_i),
        .y (col_now)
    );

    // best_next differs from best only when col_now is strictly larger,
    // which keeps the earliest position on ties.
    sw_max2 #(.W(SCORE_WIDTH)) u_best_max (
        .a (col_now),
        .b (best),
        .y (best_next)
    );

    assign cnt_full = &cnt;
    assign cnt_inc  = cnt_full ? cnt : cnt + POS_WIDTH'(1);

    // A new target starts from IDLE, or from HOLD in the same cycle the
    // pending result is accepted.
    assign start = bus.i_en && ((state == ST_IDLE) || ((state == ST_HOLD) && bus.i_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_high  <= '0;
            last_col   <= '0;
            best       <= NEUTRAL;
            cnt        <= '0;
            best_pos   <= '0;
            mode_local <= 1'b0;
            sat        <= 1'b0;
            score_q    <= '0;
            end_pos_q  <= '0;
            length_q   <= '0;
            len_sat_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (start) begin
            state      <= ST_COLLECT;
            cnt        <= POS_WIDTH'(1);
            last_high  <= bus.i_high;
            last_col   <= col_now;
            mode_local <= bus.i_local;
            best       <= col_now;
            best_pos   <= POS_WIDTH'(1);
            sat        <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (bus.i_en) begin
                        cnt       <= cnt_inc;
                        sat       <= sat | cnt_full;
                        last_high <= bus.i_high;
                        last_col  <= col_now;
                        if (best_next != best) begin
                            best     <= best_next;
                            best_pos <= cnt_inc;
                        end
                    end else begin
                        // Inputs are already back at NEUTRAL here; use the
                        // values captured on the final valid cycle.
                        state     <= ST_HOLD;
                        score_q   <= mode_local ? (last_high - NEUTRAL) : (last_col - NEUTRAL);
                        end_pos_q <= mode_local ? best_pos : cnt;
                        length_q  <= cnt;
                        len_sat_q <= sat;
                    end
                end
                ST_HOLD: begin
                    if (bus.i_ready) begin
                        state <= ST_IDLE;
                    end else if (bus.i_en) begin
                        overrun_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = (state != ST_IDLE);
    assign bus.o_valid   = (state == ST_HOLD);
    assign bus.o_score   = score_q;
    assign bus.o_end_pos = end_pos_q;
    assign bus.o_length  = length_q;
    assign bus.o_len_sat = len_sat_q;
    assign bus.o_overrun = overrun_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sw_score_collector.sv
// Bench for sw_score_collector: two instances (16-bit and 4-bit position
// counters) receive identical stimulus; results are predicted by a target-level
// model and checked by per-instance monitors against expected queues.
module tb_sw_score_collector;
    localparam int W  = 44;     // packed {len_sat, length[15:0], end_pos[15:0], score[10:0]}
    localparam int NB = 1024;   // score bias

    logic clk;
    logic rst;

    sw_score_collector_if #(.SCORE_WIDTH(11), .POS_WIDTH(16)) bus_a ();
    sw_score_collector_if #(.SCORE_WIDTH(11), .POS_WIDTH(4))  bus_b ();

    sw_score_collector #(.POS_WIDTH(16)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    sw_score_collector #(.POS_WIDTH(4))  u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q_a[$];
    logic [W-1:0] exp_q_b[$];
    int stim_m[$];
    int stim_i[$];
    int stim_h[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Target-level reference: best is the first position of the maximum
    // last-column score; counters clamp at 2^pw-1.
    function automatic logic [W-1:0] model(input bit loc, input int pw);
        int n, col, best, bpos, maxv, len, endp, sc;
        n    = stim_m.size();
        maxv = (1 << pw) - 1;
        best = -1;
        bpos = 0;
        col  = 0;
        for (int k = 0; k < n; k++) begin
            col = (stim_m[k] > stim_i[k]) ? stim_m[k] : stim_i[k];
            if (col > best) begin
                best = col;
                bpos = k + 1;
            end
        end
        sc   = loc ? (stim_h[n-1] - NB) : (col - NB);
        len  = (n > maxv) ? maxv : n;
        endp = loc ? ((bpos > maxv) ? maxv : bpos) : len;
        return {(n > maxv), 16'(len), 16'(endp), 11'(sc)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic en, input logic loc, input int m, input int i,
                               input int h, input logic rdy);
        bus_a.i_en = en;       bus_b.i_en = en;
        bus_a.i_local = loc;   bus_b.i_local = loc;
        bus_a.i_right_m = 11'(m); bus_b.i_right_m = 11'(m);
        bus_a.i_right_i = 11'(i); bus_b.i_right_i = 11'(i);
        bus_a.i_high = 11'(h); bus_b.i_high = 11'(h);
        bus_a.i_ready = rdy;   bus_b.i_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic rdy);
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), NB, NB, NB, rdy);
    endtask

    task automatic fill_random(input int n);
        stim_m.delete(); stim_i.delete(); stim_h.delete();
        for (int k = 0; k < n; k++) begin
            stim_m.push_back(int'($urandom_range(900, 1150)));
            stim_i.push_back(int'($urandom_range(900, 1150)));
            stim_h.push_back(int'($urandom_range(1024, 1200)));
        end
    endtask

    // Streams the target in stim_* and the falling-enable cycle.
    // first_rdy is driven on the first valid cycle (ignored in IDLE,
    // completes a pending handshake in HOLD).
    task automatic send_target(input bit loc, input logic first_rdy, input bit b2b);
        exp_q_a.push_back(model(loc, 16));
        exp_q_b.push_back(model(loc, 4));
        for (int k = 0; k < stim_m.size(); k++) begin
            // i_local is only meaningful on the first cycle; scramble it later.
            drive_cycle(1'b1, (k == 0) ? loc : 1'($urandom_range(0, 1)),
                        stim_m[k], stim_i[k], stim_h[k], (k == 0) ? first_rdy : 1'b0);
            if (k == 0 && b2b) begin
                check("b2b_valid_drop", 64'(bus_a.o_valid), 64'd0);
                check("b2b_busy", 64'(bus_a.o_busy), 64'd1);
                check("b2b_overrun", 64'(bus_a.o_overrun), 64'd0);
            end
        end
        idle_cycle(1'b0);
        check("latency_valid_a", 64'(bus_a.o_valid), 64'd1);
        check("latency_valid_b", 64'(bus_b.o_valid), 64'd1);
    endtask

    task automatic accept(input int delay);
        for (int d = 0; d < delay; d++) idle_cycle(1'b0);
        idle_cycle(1'b1);
        check("accept_valid_low", 64'(bus_a.o_valid), 64'd0);
        check("accept_busy_low", 64'(bus_a.o_busy), 64'd0);
    endtask

    // ---------------- monitors ----------------
    bit pres_a = 0;
    bit pres_b = 0;
    logic [W-1:0] cur_a, cur_b;

    always @(negedge clk) begin
        logic [W-1:0] act;
        act = {bus_a.o_len_sat, bus_a.o_length, bus_a.o_end_pos, bus_a.o_score};
        if (rst || !bus_a.o_valid) begin
            pres_a = 0;
        end else begin
            if (!pres_a) begin
                if (exp_q_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result_a actual=%0h expected=none", act);
                    cur_a = act;
                end else begin
                    cur_a = exp_q_a.pop_front();
                    check("result_a", 64'(act), 64'(cur_a));
                end
                pres_a = 1;
            end else begin
                check("hold_a", 64'(act), 64'(cur_a));
            end
            if (bus_a.i_ready) pres_a = 0;
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] act;
        act = {bus_b.o_len_sat, 12'd0, bus_b.o_length, 12'd0, bus_b.o_end_pos, bus_b.o_score};
        if (rst || !bus_b.o_valid) begin
            pres_b = 0;
        end else begin
            if (!pres_b) begin
                if (exp_q_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_result_b actual=%0h expected=none", act);
                    cur_b = act;
                end else begin
                    cur_b = exp_q_b.pop_front();
                    check("result_b", 64'(act), 64'(cur_b));
                end
                pres_b = 1;
            end else begin
                check("hold_b", 64'(act), 64'(cur_b));
            end
            if (bus_b.i_ready) pres_b = 0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit pending;
        bit b2b;
        int n;

        // Reset state
        rst = 1'b1;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("rst_busy", 64'(bus_a.o_busy), 64'd0);
        check("rst_valid", 64'(bus_a.o_valid), 64'd0);
        check("rst_outputs_a", 64'({bus_a.o_score, bus_a.o_end_pos, bus_a.o_length,
                                    bus_a.o_len_sat, bus_a.o_overrun}), 64'd0);
        check("rst_outputs_b", 64'({bus_b.o_score, bus_b.o_end_pos, bus_b.o_length,
                                    bus_b.o_len_sat, bus_b.o_overrun}), 64'd0);
        check("rst_state", 64'(bus_a.dbg_state), 64'(sw_pkg::ST_IDLE));
        rst = 1'b0;
        idle_cycle(1'b0);

        // Reset in the middle of a target discards it
        fill_random(5);
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, stim_m[k], stim_i[k], stim_h[k], 1'b0);
        rst = 1'b1;
        idle_cycle(1'b0);
        rst = 1'b0;
        check("midrst_busy", 64'(bus_a.o_busy), 64'd0);
        check("midrst_valid", 64'(bus_a.o_valid), 64'd0);
        fill_random(3);
        send_target(1'b0, 1'b0, 1'b0);
        accept(1);

        // Local, tie on the best column keeps the earliest position
        stim_m = '{1030, 1040, 1035, 1040};
        stim_i = '{1024, 1024, 1024, 1024};
        stim_h = '{1030, 1040, 1040, 1045};
        send_target(1'b1, 1'b0, 1'b0);
        accept(3);

        // Global, negative result from the bottom-right cell
        stim_m = '{1010, 1020, 1000};
        stim_i = '{1000, 1005, 990};
        stim_h = '{1030, 1040, 1050};
        send_target(1'b0, 1'b0, 1'b0);
        accept(0);

        // One-cycle target
        fill_random(1);
        send_target(1'b1, 1'b0, 1'b0);
        accept(1);

        // Back-to-back: accept and start in the same cycle
        fill_random(4);
        send_target(1'b1, 1'b0, 1'b0);
        fill_random(3);
        send_target(1'b0, 1'b1, 1'b1);
        accept(1);

        // Overrun: enable while holding an unclaimed result
        fill_random(3);
        send_target(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1100, 1100, 1100, 1'b0);
        drive_cycle(1'b1, 1'b0, 1110, 1000, 1150, 1'b0);
        check("overrun_set_a", 64'(bus_a.o_overrun), 64'd1);
        check("overrun_set_b", 64'(bus_b.o_overrun), 64'd1);
        check("overrun_still_hold", 64'(bus_a.o_valid), 64'd1);
        accept(0);
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("overrun_sticky", 64'(bus_a.o_overrun), 64'd1);
        rst = 1'b1;
        idle_cycle(1'b0);
        rst = 1'b0;
        check("overrun_cleared", 64'(bus_a.o_overrun), 64'd0);

        // Saturation on the narrow instance
        fill_random(20);
        send_target(1'b1, 1'b0, 1'b0);
        accept(0);
        fill_random(17);
        send_target(1'b0, 1'b0, 1'b0);
        accept(2);

        // Random targets with random acceptance delay and back-to-back starts
        pending = 0;
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(1, 20));
            fill_random(n);
            b2b = pending && ($urandom_range(0, 2) == 0);
            if (pending && !b2b) accept(int'($urandom_range(0, 3)));
            send_target(1'($urandom_range(0, 1)), b2b ? 1'b1 : 1'($urandom_range(0, 1)), b2b);
            pending = 1;
        end
        accept(1);

        idle_cycle(1'b0);
        idle_cycle(1'b0);
        check("drain_a", 64'(exp_q_a.size()), 64'd0);
        check("drain_b", 64'(exp_q_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
